// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding (LSU > WBU > retired-write buffer > RF) with a
// load-use interlock and saturating stall / load-use event counters.
module fwd_hazard_unit #(
    parameter int WIDTH  = 32,
    parameter int NREAD  = 2,
    parameter int RDEPTH = 2,
    parameter int CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    input  logic                   ex_flush,
    input  logic [5*NREAD-1:0]     ex_rf_raddr,
    input  logic [WIDTH*NREAD-1:0] ex_rf_rdata,
    input  logic                   ls_valid,
    input  logic                   ls_rf_we,
    input  logic [4:0]             ls_rf_waddr,
    input  logic                   ls_is_load,
    input  logic                   ls_mem_done,
    input  logic [WIDTH-1:0]       ls_rf_wdata_i,
    input  logic                   wb_valid,
    input  logic                   wb_rf_we,
    input  logic [4:0]             wb_rf_waddr,
    input  logic [WIDTH-1:0]       wb_rf_wdata_i,
    output logic [WIDTH*NREAD-1:0] ex_rf_rdata_o,
    output logic                   stall_ex,
    output logic [CNT_W-1:0]       perf_stall_cnt,
    output logic [CNT_W-1:0]       perf_luse_cnt
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state_reg, state_next;
    logic   luse_inc;

    logic             buf_valid_reg [RDEPTH];
    logic [4:0]       buf_addr_reg  [RDEPTH];
    logic [WIDTH-1:0] buf_data_reg  [RDEPTH];

    logic [NREAD-1:0] port_luse;
    logic             ls_wr, wb_wr, load_use, ex_fire, push;

    // x0 is hardwired, so writes to it are never forwarding candidates
    assign ls_wr = ls_valid & ls_rf_we & (ls_rf_waddr != 5'd0);
    assign wb_wr = wb_valid & wb_rf_we & (wb_rf_waddr != 5'd0);

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_port
            logic [4:0]       raddr;
            logic             ls_hit, wb_hit;
            logic [WIDTH-1:0] sel;

            assign raddr  = ex_rf_raddr[5*gi +: 5];
            assign ls_hit = ls_wr & (ls_rf_waddr == raddr);
            assign wb_hit = wb_wr & (wb_rf_waddr == raddr);

            // Lowest priority assigned first; later assignments override
            always_comb begin
                sel = ex_rf_rdata[WIDTH*gi +: WIDTH];
                for (int k = RDEPTH - 1; k >= 0; k--) begin
                    if (buf_valid_reg[k] && buf_addr_reg[k] == raddr) begin
                        sel = buf_data_reg[k];
                    end
                end
                if (wb_hit) begin
                    sel = wb_rf_wdata_i;
                end
                if (ls_hit) begin
                    sel = ls_rf_wdata_i;
                end
            end

            assign ex_rf_rdata_o[WIDTH*gi +: WIDTH] = sel;
            assign port_luse[gi] = ls_hit & ls_is_load & ~ls_mem_done;
        end
    endgenerate

    assign load_use = ex_valid & ~ex_flush & (|port_luse);
    assign stall_ex = load_use & ~rst;
    assign ex_fire  = ex_valid & ~stall_ex;
    assign push     = wb_wr & ~ex_flush;

    // The RF has no write-through, so WB writes seen while EX waits are
    // retained until the held instruction finally leaves EX.
    always_ff @(posedge clk) begin
        if (rst || ex_flush) begin
            for (int k = 0; k < RDEPTH; k++) begin
                buf_valid_reg[k] <= 1'b0;
            end
        end else if (push) begin
            buf_valid_reg[0] <= 1'b1;
            buf_addr_reg[0]  <= wb_rf_waddr;
            buf_data_reg[0]  <= wb_rf_wdata_i;
            for (int k = 1; k < RDEPTH; k++) begin
                buf_valid_reg[k] <= buf_valid_reg[k-1] & ~ex_fire;
                buf_addr_reg[k]  <= buf_addr_reg[k-1];
                buf_data_reg[k]  <= buf_data_reg[k-1];
            end
        end else if (ex_fire) begin
            for (int k = 0; k < RDEPTH; k++) begin
                buf_valid_reg[k] <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        luse_inc   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load_use) begin
                    state_next = WAIT;
                    luse_inc   = 1'b1;
                end
            end
            WAIT: begin
                if (ls_mem_done || ex_flush || !ls_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            perf_stall_cnt <= '0;
            perf_luse_cnt  <= '0;
        end else begin
            state_reg <= state_next;
            if (stall_ex && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
            if (luse_inc && perf_luse_cnt != '1) begin
                perf_luse_cnt <= perf_luse_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a queue-based reference model checked every
// cycle, plus literal expectations for the named scenarios and counter saturation.
module tb_fwd_hazard_unit;

    localparam int W = 32;
    localparam int NR = 2;
    localparam int RD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid, ex_flush;
    logic [9:0]    ex_rf_raddr;
    logic [63:0]   ex_rf_rdata;
    logic          ls_valid, ls_rf_we, ls_is_load, ls_mem_done;
    logic [4:0]    ls_rf_waddr;
    logic [31:0]   ls_rf_wdata_i;
    logic          wb_valid, wb_rf_we;
    logic [4:0]    wb_rf_waddr;
    logic [31:0]   wb_rf_wdata_i;
    logic [63:0]   rdata_a, rdata_b;
    logic          stall_a, stall_b;
    logic [31:0]   scnt_a, lcnt_a;
    logic [3:0]    scnt_b, lcnt_b;

    int n_cmp = 0;
    int n_bad = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.WIDTH(W), .NREAD(NR), .RDEPTH(RD), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_flush(ex_flush),
        .ex_rf_raddr(ex_rf_raddr), .ex_rf_rdata(ex_rf_rdata),
        .ls_valid(ls_valid), .ls_rf_we(ls_rf_we), .ls_rf_waddr(ls_rf_waddr),
        .ls_is_load(ls_is_load), .ls_mem_done(ls_mem_done), .ls_rf_wdata_i(ls_rf_wdata_i),
        .wb_valid(wb_valid), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
        .wb_rf_wdata_i(wb_rf_wdata_i), .ex_rf_rdata_o(rdata_a), .stall_ex(stall_a),
        .perf_stall_cnt(scnt_a), .perf_luse_cnt(lcnt_a)
    );

    fwd_hazard_unit #(.WIDTH(W), .NREAD(NR), .RDEPTH(RD), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_flush(ex_flush),
        .ex_rf_raddr(ex_rf_raddr), .ex_rf_rdata(ex_rf_rdata),
        .ls_valid(ls_valid), .ls_rf_we(ls_rf_we), .ls_rf_waddr(ls_rf_waddr),
        .ls_is_load(ls_is_load), .ls_mem_done(ls_mem_done), .ls_rf_wdata_i(ls_rf_wdata_i),
        .wb_valid(wb_valid), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
        .wb_rf_wdata_i(wb_rf_wdata_i), .ex_rf_rdata_o(rdata_b), .stall_ex(stall_b),
        .perf_stall_cnt(scnt_b), .perf_luse_cnt(lcnt_b)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t    retired[$];       // newest at front
    bit     m_wait = 1'b0;
    longint m_stall = 0;
    longint m_luse = 0;

    function automatic logic [4:0] raddr_of(int i);
        return ex_rf_raddr[5*i +: 5];
    endfunction

    function automatic bit ls_pending(int i);
        return ls_valid && ls_rf_we && ls_rf_waddr != 0 && ls_rf_waddr == raddr_of(i)
               && ls_is_load && !ls_mem_done;
    endfunction

    function automatic bit exp_stall();
        bit any = 0;
        for (int i = 0; i < NR; i++) any |= ls_pending(i);
        return !rst && ex_valid && !ex_flush && any;
    endfunction

    function automatic logic [31:0] exp_operand(int i);
        logic [4:0] r = raddr_of(i);
        if (r != 0 && ls_valid && ls_rf_we && ls_rf_waddr == r) return ls_rf_wdata_i;
        if (r != 0 && wb_valid && wb_rf_we && wb_rf_waddr == r) return wb_rf_wdata_i;
        foreach (retired[k]) if (r != 0 && retired[k].a == r) return retired[k].d;
        return ex_rf_rdata[32*i +: 32];
    endfunction

    function automatic longint sat(longint v, longint mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk) begin
        bit st;
        st = exp_stall();
        if (rst) begin
            retired.delete();
            m_wait = 0; m_stall = 0; m_luse = 0;
        end else begin
            if (st) m_stall++;
            if (!m_wait && st) begin
                m_wait = 1; m_luse++;
            end else if (m_wait && (ls_mem_done || ex_flush || !ls_valid)) begin
                m_wait = 0;
            end
            if (ex_flush) begin
                retired.delete();
            end else begin
                if (ex_valid && !st) retired.delete();
                if (wb_valid && wb_rf_we && wb_rf_waddr != 0) begin
                    wr_t e;
                    e.a = wb_rf_waddr; e.d = wb_rf_wdata_i;
                    retired.push_front(e);
                    if (retired.size() > RD) void'(retired.pop_back());
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model stall_a", {63'd0, stall_a}, {63'd0, exp_stall()});
            chk("model stall_b", {63'd0, stall_b}, {63'd0, exp_stall()});
            for (int i = 0; i < NR; i++) begin
                if (!ls_pending(i)) begin
                    chk("model operand_a", {32'd0, rdata_a[32*i +: 32]}, {32'd0, exp_operand(i)});
                    chk("model operand_b", {32'd0, rdata_b[32*i +: 32]}, {32'd0, exp_operand(i)});
                end
            end
            chk("model stall_cnt_a", {32'd0, scnt_a}, 64'(sat(m_stall, 64'hFFFF_FFFF)));
            chk("model luse_cnt_a", {32'd0, lcnt_a}, 64'(sat(m_luse, 64'hFFFF_FFFF)));
            chk("model stall_cnt_b", {60'd0, scnt_b}, 64'(sat(m_stall, 15)));
            chk("model luse_cnt_b", {60'd0, lcnt_b}, 64'(sat(m_luse, 15)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [4:0] r0, input logic [4:0] r1,
                          input logic [31:0] d0, input logic [31:0] d1);
        ex_valid = 1'b1;
        ex_rf_raddr = {r1, r0};
        ex_rf_rdata = {d1, d0};
    endtask

    task automatic set_ls(input logic v, input logic [4:0] a, input logic ld,
                          input logic done, input logic [31:0] d);
        ls_valid = v; ls_rf_we = v; ls_rf_waddr = a;
        ls_is_load = ld; ls_mem_done = done; ls_rf_wdata_i = d;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb_valid = v; wb_rf_we = v; wb_rf_waddr = a; wb_rf_wdata_i = d;
    endtask

    task automatic line(input string s);
        $display("[%0t] %s stall=%0b op0=%0h op1=%0h scnt=%0d lcnt=%0d",
                 $time, s, stall_a, rdata_a[31:0], rdata_a[63:32], scnt_a, lcnt_a);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 0; ex_flush = 0;
        set_ex(0, 0, 0, 0); ex_valid = 0;
        set_ls(0, 0, 0, 0, 0); set_wb(0, 0, 0);
        cyc();
        check_en = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("reset stall_cnt", {32'd0, scnt_a}, 64'd0);
        chk("reset luse_cnt", {32'd0, lcnt_a}, 64'd0);
        chk("reset stall", {63'd0, stall_a}, 64'd0);
        line("reset");

        // LS beats WB on the same register
        set_ls(1, 5, 0, 0, 32'h11); set_wb(1, 5, 32'h22);
        set_ex(5, 0, 32'h77, 32'h99);
        #1;
        chk("ls over wb", {32'd0, rdata_a[31:0]}, 64'h11);
        chk("ls over wb stall", {63'd0, stall_a}, 64'd0);
        line("ls>wb");
        cyc();
        set_ls(0, 0, 0, 0, 0); set_wb(0, 0, 0);
        #1;
        chk("same-edge push kept", {32'd0, rdata_a[31:0]}, 64'h22);
        line("buffer");
        cyc();
        #1;
        chk("buffer cleared on fire", {32'd0, rdata_a[31:0]}, 64'h77);
        line("rf");

        // load-use on rs2, three wait cycles
        set_ls(1, 6, 1, 0, 32'hDEAD); set_ex(1, 6, 32'h10, 32'h20);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("load-use stall", {63'd0, stall_a}, 64'd1);
            line("luse wait");
            cyc();
        end
        ls_mem_done = 1'b1; ls_rf_wdata_i = 32'hABCD;
        #1;
        chk("load data release", {63'd0, stall_a}, 64'd0);
        chk("load data fwd", {32'd0, rdata_a[63:32]}, 64'hABCD);
        line("luse done");
        cyc();
        chk("stall count 3", {32'd0, scnt_a}, 64'd3);
        chk("luse count 1", {32'd0, lcnt_a}, 64'd1);

        // WB retires x7 while EX is held
        set_ls(1, 6, 1, 0, 0); set_wb(1, 7, 32'h55); set_ex(7, 6, 0, 0);
        #1;
        chk("retire wb hit", {32'd0, rdata_a[31:0]}, 64'h55);
        line("retire wb");
        cyc();
        set_wb(0, 0, 0);
        #1;
        chk("retire held", {63'd0, stall_a}, 64'd1);
        chk("retire from buffer", {32'd0, rdata_a[31:0]}, 64'h55);
        line("retire buf");
        cyc();
        ls_mem_done = 1'b1; ls_rf_wdata_i = 32'h1234;
        #1;
        chk("retire release op0", {32'd0, rdata_a[31:0]}, 64'h55);
        chk("retire release op1", {32'd0, rdata_a[63:32]}, 64'h1234);
        line("retire release");
        cyc();
        chk("stall count 5", {32'd0, scnt_a}, 64'd5);

        // x0 never forwards or stalls
        set_ls(1, 0, 0, 0, 32'hFFFF); set_wb(1, 0, 32'hFFFF); set_ex(0, 0, 0, 0);
        #1;
        chk("x0 op0", {32'd0, rdata_a[31:0]}, 64'd0);
        chk("x0 op1", {32'd0, rdata_a[63:32]}, 64'd0);
        line("x0 alu");
        ls_is_load = 1'b1;
        #1;
        chk("x0 load no stall", {63'd0, stall_a}, 64'd0);
        line("x0 load");
        cyc();
        set_ls(0, 0, 0, 0, 0); set_wb(0, 0, 0);

        // flush while waiting on a load
        set_ls(1, 8, 1, 0, 0); set_wb(1, 9, 32'h99); set_ex(8, 9, 32'h1, 32'h2);
        #1;
        chk("flush pre stall", {63'd0, stall_a}, 64'd1);
        line("flush pre");
        cyc();
        ex_flush = 1'b1; set_wb(1, 10, 32'hAA);
        #1;
        chk("flush stall", {63'd0, stall_a}, 64'd0);
        line("flush");
        cyc();
        ex_flush = 1'b0; set_ls(0, 0, 0, 0, 0); set_wb(0, 0, 0);
        set_ex(9, 10, 32'h3, 32'h4);
        #1;
        chk("flush cleared x9", {32'd0, rdata_a[31:0]}, 64'h3);
        chk("flush dropped x10", {32'd0, rdata_a[63:32]}, 64'h4);
        line("after flush");
        cyc();
        set_ls(1, 8, 1, 0, 0); set_ex(8, 0, 0, 0);
        cyc();
        chk("rearm luse 4", {32'd0, lcnt_a}, 64'd4);
        line("rearm");
        ls_mem_done = 1'b1;
        cyc();
        set_ls(0, 0, 0, 0, 0);

        // reset in the middle of a stall
        set_ls(1, 8, 1, 0, 0); set_wb(1, 11, 32'h5A); set_ex(8, 11, 0, 32'h6);
        cyc();
        rst = 1'b1; set_wb(0, 0, 0);
        #1;
        chk("rst forces no stall", {63'd0, stall_a}, 64'd0);
        line("rst");
        cyc();
        rst = 1'b0; set_ls(0, 0, 0, 0, 0);
        #1;
        chk("rst buffer empty", {32'd0, rdata_a[63:32]}, 64'h6);
        chk("rst counters", {32'd0, scnt_a}, 64'd0);
        line("after rst");
        cyc();

        // 20-cycle stall: saturation on the 4-bit instance, buffer depth/duplicates
        set_ls(1, 8, 1, 0, 0); set_ex(8, 11, 0, 32'h6);
        for (int i = 0; i < 20; i++) begin
            if (i == 0) set_wb(1, 11, 32'hA);
            else if (i == 1) set_wb(1, 12, 32'hB);
            else if (i == 2) set_wb(1, 12, 32'hC);
            else set_wb(0, 0, 0);
            if (i == 3) begin
                #1;
                chk("oldest dropped", {32'd0, rdata_a[63:32]}, 64'h6);
                ex_rf_raddr[9:5] = 5'd12;
                #1;
                chk("duplicate newest wins", {32'd0, rdata_a[63:32]}, 64'hC);
                line("buffer depth");
            end
            cyc();
        end
        chk("stall count 20", {32'd0, scnt_a}, 64'd20);
        chk("saturated 15", {60'd0, scnt_b}, 64'd15);
        chk("narrow luse 1", {60'd0, lcnt_b}, 64'd1);
        line("saturation");
        ls_mem_done = 1'b1;
        cyc();
        set_ls(0, 0, 0, 0, 0); ex_valid = 1'b0;
        cyc();
        cyc();
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
